sync_fifo_flags: RTL and testbench
==================================

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two >=2.
REQ-003 Parameter PTR_WIDTH, default 4, address width, SHALL equal log2(DEPTH).
REQ-004 Parameter AF_THRESH, default 14, almost-full level (1..DEPTH-1).
REQ-005 Parameter AE_THRESH, default 2, almost-empty level (1..DEPTH-1).
REQ-006 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-007 clk_i  input  1  single clock; all state on rising edge.
REQ-008 rst_n_i  input  1  asynchronous, active-low reset.
REQ-009 wr_en_i  input  1  write request.
REQ-010 wdata_i  input  WIDTH  write data.
REQ-011 rd_en_i  input  1  read request.
REQ-012 clr_err_i  input  1  clears sticky error flags.
REQ-013 rdata_o  output  WIDTH  read data.
REQ-014 full_o / empty_o  output  1 each  occupancy == DEPTH / == 0.
REQ-015 almost_full_o / almost_empty_o  output  1 each  count >= AF_THRESH / count <= AE_THRESH.
REQ-016 count_o  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-017 error_o  output  1  one-cycle pulse flagging a rejected access.
REQ-018 overflow_o / underflow_o  output  1 each  sticky rejected-write / rejected-read flags.

Function
REQ-019 Write accepted iff wr_en_i and (not full_o, or read accepted same cycle); accepted write stores wdata_i at wr_ptr, wr_ptr increments.
REQ-020 Read accepted iff rd_en_i and not empty_o; rd_ptr increments.
REQ-021 Full with simultaneous rd+wr: both accepted, count unchanged, no error.
REQ-022 Empty with simultaneous rd+wr: write accepted, read rejected (underflow), count becomes 1.
REQ-023 Pointers SHALL be PTR_WIDTH+1 bits; address = low PTR_WIDTH bits; MSB toggles on wrap; count_o = wr_ptr - rd_ptr modulo 2^(PTR_WIDTH+1).
REQ-024 All flags SHALL be combinational from registered pointers only; they update the cycle after the causing edge.
REQ-025 FWFT=0: rdata_o registered, carries popped word one cycle after the accepting edge; holds value when no read accepted.
REQ-026 FWFT=1: rdata_o SHALL show the head entry whenever empty_o is 0 (zero latency); rd_en_i acknowledges/pops it; value is 0 when empty.
REQ-027 Rejected write: data discarded, memory/pointers unchanged, overflow_o set, error_o pulses next cycle.
REQ-028 Rejected read: pointers unchanged, rdata_o unchanged, underflow_o set, error_o pulses next cycle.
REQ-029 clr_err_i clears overflow_o and underflow_o; a new error in the same cycle wins (flag stays set).
REQ-030 Sustained DEPTH-stream wrap-around SHALL preserve order with no loss.

Reset
REQ-031 rst_n_i low SHALL immediately clear pointers, count_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, error_o=0, overflow_o=0, underflow_o=0, rdata_o=0.
REQ-032 Memory contents need not be reset; reset mid-operation discards all stored data; first access after deassertion behaves as from empty.

Structure
REQ-033 Shared header fifo_pkg SHALL hold default WIDTH/DEPTH/threshold constants and FWFT mode encodings.
REQ-034 Storage SHALL be sub-module fifo_mem: DEPTH x WIDTH array, synchronous write, asynchronous read, no reset.
REQ-035 Top SHALL contain pointer, count, flag, error and read-mode logic only.

Verification
REQ-036 Write 16 random words then read 16 (FWFT=0) -> data returned in order one cycle after each read; full_o=1 after 16th write, empty_o=1 after 16th read.
REQ-037 17 consecutive writes -> 17th rejected, error_o one pulse, overflow_o=1 until clr_err_i, count_o stays 16.
REQ-038 Fill then 17 reads -> 17th rejected, error_o pulse, underflow_o=1, rdata_o keeps 16th word.
REQ-039 Count 13->14 on write -> almost_full_o rises; count 3->2 on read -> almost_empty_o rises; full with rd+wr -> count 16, no error.
REQ-040 FWFT=1, write 0xA5 into empty -> rdata_o=0xA5 the next cycle without rd_en_i; 500 concurrent random wr/rd with rst_n_i pulsed mid-run -> scoreboard matches, all outputs at reset values during reset.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the flagged synchronous FIFO: default geometry,
// flag thresholds and read-mode encodings.
package fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 8;
    localparam int unsigned DEFAULT_DEPTH     = 16;
    localparam int unsigned DEFAULT_PTR_WIDTH = 4;
    localparam int unsigned DEFAULT_AF_THRESH = 14;
    localparam int unsigned DEFAULT_AE_THRESH = 2;

    // Read-mode encodings for the FWFT parameter
    localparam int unsigned FWFT_REGISTERED   = 0;
    localparam int unsigned FWFT_FALLTHROUGH  = 1;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH array, synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module fifo_mem #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PTR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [PTR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [PTR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]     rdata_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy flags, sticky overflow/underflow and a
// one-cycle error pulse; read port is either registered or fall-through.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned PTR_WIDTH = DEFAULT_PTR_WIDTH,
    parameter int unsigned AF_THRESH = DEFAULT_AF_THRESH,
    parameter int unsigned AE_THRESH = DEFAULT_AE_THRESH,
    parameter int unsigned FWFT      = FWFT_REGISTERED
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               wr_en_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic               rd_en_i,
    input  logic               clr_err_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               almost_full_o,
    output logic               almost_empty_o,
    output logic [PTR_WIDTH:0] count_o,
    output logic               error_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    localparam int unsigned CW = PTR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic             rd_acc;
    logic             wr_acc;
    logic             wr_rej;
    logic             rd_rej;
    logic [WIDTH-1:0] head;

    // Occupancy and flags come only from the registered pointers; the extra
    // MSB distinguishes full from empty when the addresses coincide.
    assign count_o        = wr_ptr - rd_ptr;
    assign full_o         = (count_o == FULL_LVL);
    assign empty_o        = (count_o == '0);
    assign almost_full_o  = (count_o >= AF_LVL);
    assign almost_empty_o = (count_o <= AE_LVL);

    // A read frees a slot, so a write into a full FIFO succeeds alongside it
    always_comb begin
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        rd_acc = rd_en_i & ~empty_o;
        wr_acc = wr_en_i & (~full_o | rd_acc);
        wr_rej = wr_en_i & ~wr_acc;
        rd_rej = rd_en_i & ~rd_acc;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    // Sticky flags: a fresh rejection in the clearing cycle keeps the flag set
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            error_o     <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            error_o     <= wr_rej | rd_rej;
            overflow_o  <= wr_rej | (overflow_o  & ~clr_err_i);
            underflow_o <= rd_rej | (underflow_o & ~clr_err_i);
        end
    end

    fifo_mem #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk     (clk_i),
        .we      (wr_acc),
        .waddr   (wr_ptr[PTR_WIDTH-1:0]),
        .wdata   (wdata_i),
        .raddr   (rd_ptr[PTR_WIDTH-1:0]),
        .rdata_c (head)
    );

    generate
        if (FWFT == FWFT_FALLTHROUGH) begin : g_fwft
            assign rdata_o = empty_o ? '0 : head;
        end else begin : g_registered
            logic [WIDTH-1:0] rdata_q;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    rdata_q <= '0;
                end else if (rd_acc) begin
                    rdata_q <= head;
                end
            end

            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a registered-read and a fall-through FIFO with identical stimulus
// and compares both against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic       clr_err;

    logic [7:0] rdata_0, rdata_1;
    logic       full_0, full_1, empty_0, empty_1;
    logic       af_0, af_1, ae_0, ae_1;
    logic [4:0] count_0, count_1;
    logic       err_0, err_1, ovf_0, ovf_1, unf_0, unf_1;

    int n_pass = 0;
    int n_checks = 0;

    // Reference model: contents as a queue, plus registered-read and error state
    int         q[$];
    logic [7:0] m_rd0;
    bit         m_err, m_ovf, m_unf;

    always #5 clk = ~clk;

    sync_fifo_flags #(.FWFT(0)) u_reg (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wdata_i(wdata),
        .rd_en_i(rd_en), .clr_err_i(clr_err), .rdata_o(rdata_0),
        .full_o(full_0), .empty_o(empty_0), .almost_full_o(af_0),
        .almost_empty_o(ae_0), .count_o(count_0), .error_o(err_0),
        .overflow_o(ovf_0), .underflow_o(unf_0)
    );

    sync_fifo_flags #(.FWFT(1)) u_fwft (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wdata_i(wdata),
        .rd_en_i(rd_en), .clr_err_i(clr_err), .rdata_o(rdata_1),
        .full_o(full_1), .empty_o(empty_1), .almost_full_o(af_1),
        .almost_empty_o(ae_1), .count_o(count_1), .error_o(err_1),
        .overflow_o(ovf_1), .underflow_o(unf_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int n;
        logic [7:0] head;
        n = q.size();
        head = (n > 0) ? 8'(q[0]) : 8'h00;
        check("count_reg",  32'(count_0), 32'(n));
        check("count_fwft", 32'(count_1), 32'(n));
        check("full_reg",   32'(full_0),  32'(n == DEPTH));
        check("full_fwft",  32'(full_1),  32'(n == DEPTH));
        check("empty_reg",  32'(empty_0), 32'(n == 0));
        check("empty_fwft", 32'(empty_1), 32'(n == 0));
        check("afull_reg",  32'(af_0),    32'(n >= 14));
        check("afull_fwft", 32'(af_1),    32'(n >= 14));
        check("aempty_reg", 32'(ae_0),    32'(n <= 2));
        check("aempty_fwft",32'(ae_1),    32'(n <= 2));
        check("error_reg",  32'(err_0),   32'(m_err));
        check("error_fwft", 32'(err_1),   32'(m_err));
        check("ovf_reg",    32'(ovf_0),   32'(m_ovf));
        check("ovf_fwft",   32'(ovf_1),   32'(m_ovf));
        check("unf_reg",    32'(unf_0),   32'(m_unf));
        check("unf_fwft",   32'(unf_1),   32'(m_unf));
        check("rdata_reg",  32'(rdata_0), 32'(m_rd0));
        check("rdata_fwft", 32'(rdata_1), 32'(head));
    endtask

    task automatic model_reset();
        q.delete();
        m_rd0 = 8'h00;
        m_err = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock: apply inputs, take the edge, advance the model, compare
    task automatic step(input bit wr, input logic [7:0] wd, input bit rd, input bit clr);
        bit rd_ok, wr_ok;
        wr_en = wr; wdata = wd; rd_en = rd; clr_err = clr;
        @(posedge clk);
        #1;
        rd_ok = rd && (q.size() > 0);
        wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
        if (rd_ok) m_rd0 = 8'(q.pop_front());
        if (wr_ok) q.push_back(int'(wd));
        m_err = (wr && !wr_ok) || (rd && !rd_ok);
        m_ovf = (wr && !wr_ok) || (m_ovf && !clr);
        m_unf = (rd && !rd_ok) || (m_unf && !clr);
        check_all();
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wdata = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all();

        // Fill, then a 17th write is rejected
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        check("full_after_16", 32'(full_0), 32'd1);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("err_pulse_ovf", 32'(err_0), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_sticky", 32'(ovf_0), 32'd1);
        check("count_held", 32'(count_0), 32'd16);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous read and write, then full write racing a clear
        step(1'b1, 8'($urandom), 1'b1, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Drain in order, then a 17th read is rejected
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("empty_after_16", 32'(empty_0), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("err_pulse_unf", 32'(err_0), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Threshold walks: up through almost-full, down through almost-empty
        for (int i = 0; i < 15; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Empty with simultaneous read and write: write lands, read underflows
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        check("count_one", 32'(count_0), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // Fall-through: a word written into an empty FIFO appears with no read
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("fwft_a5", 32'(rdata_1), 32'h000000A5);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised concurrent traffic with a reset in the middle
        for (int i = 0; i < 500; i++) begin
            if (i == 250) pulse_reset();
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
